// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: legal prescale values, default frame
// length and the width of the bit-position counter.
package uart_rx_pkg;

  localparam int PRESC_8        = 8;
  localparam int PRESC_16       = 16;
  localparam int PRESC_32       = 32;

  localparam int FRAME_BITS_DEF = 11;
  localparam int BIT_CNT_W      = 4;

  // Map a raw prescale request onto a legal ratio; anything unknown runs at 8.
  function automatic int eff_presc(input int p);
    if (p == PRESC_16) return PRESC_16;
    if (p == PRESC_32) return PRESC_32;
    return PRESC_8;
  endfunction

endpackage

// File: rtl/data_sampler_edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter and bit-position counter.
// The edge counter runs 0..presc-1 while enabled; its wrap advances the bit
// counter, which wraps after FRAME_BITS-1. Dropping the enable clears both.
module edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int PRESC_W    = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [PRESC_W-1:0]   presc_i,
  output logic [PRESC_W-1:0]   edge_cnt_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  logic [PRESC_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;

  // Next-state: count while enabled, otherwise restart the frame from zero.
  always_comb begin
    edge_cnt_d = '0;
    bit_cnt_d  = '0;
    if (en_i) begin
      if (edge_cnt_q == presc_i - PRESC_W'(1)) begin
        edge_cnt_d = '0;
        if (bit_cnt_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        end
      end else begin
        edge_cnt_d = edge_cnt_q + PRESC_W'(1);
        bit_cnt_d  = bit_cnt_q;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign edge_cnt_o = edge_cnt_q;
  assign bit_cnt_o  = bit_cnt_q;

endmodule

// File: rtl/data_sampler.sv
// data_sampler: oversampling front end of the UART receiver.
// Samples RX_IN around each bit centre and emits one resolved bit per bit
// period with a one-cycle sample_valid strobe at edge_cnt == mid+2.
// Optional feature macro: DATA_SAMPLER_MAJORITY_EN selects a 3-sample
// majority vote (mid-1, mid, mid+1); without it the centre sample is used.
// PRESC_W must be at least 6 so that a prescale of 32 is representable.
module data_sampler
  import uart_rx_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int PRESC_W    = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic [PRESC_W-1:0]   prescale,
  input  logic                 dat_samp_en,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sampled_bit,
  output logic                 sample_valid
);

  logic [PRESC_W-1:0] presc_eff;
  logic [PRESC_W-1:0] mid;
  logic               vote;
  logic               s1_q, s1_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               sample_valid_q, sample_valid_d;

  assign presc_eff = PRESC_W'(eff_presc(int'(prescale)));
  assign mid       = presc_eff >> 1;

  edge_bit_counter #(
    .FRAME_BITS (FRAME_BITS),
    .PRESC_W    (PRESC_W)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .en_i       (dat_samp_en),
    .presc_i    (presc_eff),
    .edge_cnt_o (edge_cnt),
    .bit_cnt_o  (bit_cnt)
  );

`ifdef DATA_SAMPLER_MAJORITY_EN
  logic s0_q, s0_d;
  logic s2_q, s2_d;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the early and late samples around the bit centre while enabled.
  always_comb begin
    s0_d = s0_q;
    s2_d = s2_q;
    if (dat_samp_en && (edge_cnt == mid - PRESC_W'(1))) s0_d = RX_IN;
    if (dat_samp_en && (edge_cnt == mid + PRESC_W'(1))) s2_d = RX_IN;
  end

  // Early/late sample registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s0_q <= s0_d;
      s2_q <= s2_d;
    end
  end

  assign vote = maj3(s0_q, s1_q, s2_q);
`else
  assign vote = s1_q;
`endif

  // Centre sample capture, and the strobe one edge after the last capture.
  always_comb begin
    s1_d           = s1_q;
    sample_valid_d = 1'b0;
    sampled_bit_d  = sampled_bit_q;
    if (dat_samp_en && (edge_cnt == mid)) s1_d = RX_IN;
    if (dat_samp_en && (edge_cnt == mid + PRESC_W'(2))) begin
      sample_valid_d = 1'b1;
      sampled_bit_d  = vote;
    end
  end

  // Centre sample, resolved bit and strobe registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q           <= 1'b0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
    end else begin
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_data_sampler.sv
// Directed bench for data_sampler. Inputs change 1 ns after the rising edge
// and outputs are observed at that point, so after k enabled edges the
// visible edge_cnt is k mod P and a strobe registered on the edge where
// edge_cnt was mid+2 is visible when edge_cnt reads mid+3.
module tb_data_sampler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int n_chk  = 0;
  int n_pass = 0;

  data_sampler #(.FRAME_BITS(11), .PRESC_W(6)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    dat_samp_en = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  int strobes;
  int first;

  initial begin
    RST = 1'b1; RX_IN = 1'b1; prescale = 6'd8; dat_samp_en = 1'b0;

    // Reset state
    do_reset();
    chk("rst_edge", 32'(edge_cnt), 0);
    chk("rst_bit",  32'(bit_cnt), 0);
    chk("rst_sb",   32'(sampled_bit), 0);
    chk("rst_sv",   32'(sample_valid), 0);

    // P=8, RX_IN=1, one full frame of 88 enabled cycles
    dat_samp_en = 1'b1;
    strobes = 0;
    for (int k = 1; k <= 88; k++) begin
      step();
      chk("p8_edge", 32'(edge_cnt), 32'(k % 8));
      chk("p8_bit",  32'(bit_cnt), 32'((k / 8) % 11));
      chk("p8_sv",   32'(sample_valid), 32'(k % 8 == 7));
      if (sample_valid) begin
        strobes++;
        chk("p8_sb", 32'(sampled_bit), 1);
      end
    end
    chk("frame_strobes", 32'(strobes), 11);
    chk("frame_end_bit", 32'(bit_cnt), 0);

    // Enable dropped at edge_cnt 3 of bit 1
    do_reset();
    dat_samp_en = 1'b1; RX_IN = 1'b1;
    for (int k = 1; k <= 11; k++) step();
    chk("drop_pre_edge", 32'(edge_cnt), 3);
    chk("drop_pre_bit",  32'(bit_cnt), 1);
    dat_samp_en = 1'b0; RX_IN = 1'b0;
    step();
    chk("drop_edge", 32'(edge_cnt), 0);
    chk("drop_bit",  32'(bit_cnt), 0);
    for (int k = 0; k < 4; k++) begin
      chk("drop_sv",   32'(sample_valid), 0);
      chk("drop_hold", 32'(sampled_bit), 1);
      step();
    end
    // Re-enable: first strobe 7 cycles later, carrying the new line value
    dat_samp_en = 1'b1;
    first = -1;
    for (int j = 1; j <= 20 && first < 0; j++) begin
      step();
      if (sample_valid) first = j;
    end
    chk("reen_latency", 32'(first), 7);
    chk("reen_sb", 32'(sampled_bit), 0);

    // Reset pulsed mid-frame at bit_cnt 5 with enable still high
    do_reset();
    dat_samp_en = 1'b1; RX_IN = 1'b1;
    for (int k = 1; k <= 47; k++) step();
    chk("mrst_pre_bit", 32'(bit_cnt), 5);
    chk("mrst_pre_sv",  32'(sample_valid), 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mrst_edge", 32'(edge_cnt), 0);
    chk("mrst_bit",  32'(bit_cnt), 0);
    chk("mrst_sb",   32'(sampled_bit), 0);
    chk("mrst_sv",   32'(sample_valid), 0);
    step();
    chk("mrst_resume", 32'(edge_cnt), 1);

    // P=16, single-cycle high glitch at the centre sample
    do_reset();
    prescale = 6'd16; RX_IN = 1'b0; dat_samp_en = 1'b1;
    for (int k = 1; k <= 8; k++) step();
    chk("glitch_at", 32'(edge_cnt), 8);
    RX_IN = 1'b1;
    step();
    RX_IN = 1'b0;
    step();
    chk("glitch_sv_early", 32'(sample_valid), 0);
    step();
    chk("glitch_sv", 32'(sample_valid), 1);
`ifdef DATA_SAMPLER_MAJORITY_EN
    chk("glitch_sb", 32'(sampled_bit), 0);
`else
    chk("glitch_sb", 32'(sampled_bit), 1);
`endif

    // Illegal prescale 12 behaves as 8
    do_reset();
    prescale = 6'd12; RX_IN = 1'b1; dat_samp_en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("p12_edge", 32'(edge_cnt), 32'(k % 8));
      chk("p12_sv",   32'(sample_valid), 32'(k % 8 == 7));
    end

    // P=32: strobe on the edge where edge_cnt is 18
    do_reset();
    prescale = 6'd32; RX_IN = 1'b1; dat_samp_en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("p32_edge", 32'(edge_cnt), 32'(k % 32));
      chk("p32_sv",   32'(sample_valid), 32'(k % 32 == 19));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_sampler.md
# data_sampler

Oversampling front end of the UART receiver. Counts oversampling edges and bit positions inside a frame, samples the serial line around each bit centre, and emits one resolved bit per bit period as `sampled_bit` with a one-cycle `sample_valid` strobe. Sits directly upstream of the deserializer and the frame-check logic; the Rx FSM drives its enable and reads its counters.

## Interface
- `FRAME_BITS`, default 11: bits per frame (start + 8 data + parity + stop); `bit_cnt` wraps after `FRAME_BITS-1`.
- `PRESC_W`, default 6: width of the `prescale` input.
- `CLK`  in  1: system clock; all logic on the rising edge.
- `RST`  in  1: synchronous reset, active-high.
- `RX_IN`  in  1: serial line, already synchronized to `CLK` upstream; this block contains no synchronizer.
- `prescale`  in  `PRESC_W`: oversampling ratio; legal values are 8, 16 and 32.
- `dat_samp_en`  in  1: run enable from the Rx FSM.
- `edge_cnt`  out  `PRESC_W`: current oversampling edge within the bit, 0..prescale-1.
- `bit_cnt`  out  4: current bit index within the frame, 0..FRAME_BITS-1.
- `sampled_bit`  out  1: resolved bit value.
- `sample_valid`  out  1: one-cycle strobe; `sampled_bit` is updated in the same cycle.

## Operation
- Define effective prescale P = `prescale` when it is 8, 16 or 32; any other value is treated as 8. Define mid = P/2.
- The edge counter increments each cycle while `dat_samp_en` is high. At `edge_cnt == P-1` it wraps to 0 and `bit_cnt` increments.
- `bit_cnt` wraps to 0 when it increments past `FRAME_BITS-1`.
- Sample registers s0, s1 and s2 capture `RX_IN` on the edges where `edge_cnt` is mid-1, mid and mid+1, respectively.
- On the edge where `edge_cnt == mid+2`:
  - `sampled_bit` is loaded with the resolved value (see Configuration).
  - `sample_valid` goes high for exactly that one cycle.
- While `dat_samp_en` is low:
  - `edge_cnt` and `bit_cnt` are forced to 0 on the next edge.
  - `sample_valid` is 0.
  - `sampled_bit` and s0..s2 hold their values.
- When `dat_samp_en` is dropped mid-bit, the partial bit is discarded: no strobe occurs for it. When it is re-asserted, counting restarts from `edge_cnt` 0, `bit_cnt` 0.
- A change of `prescale` takes effect immediately. Changing it while enabled is not supported; the Rx FSM changes it only while `dat_samp_en` is low.

## Timing
- Reset values: `edge_cnt` 0, `bit_cnt` 0, `sampled_bit` 0, `sample_valid` 0, s0..s2 0.
- `RST` has priority over `dat_samp_en`; reset asserted mid-frame clears all state on the next edge.
- Latency from the last sample capture to the strobe: 1 cycle. The strobe occurs at `edge_cnt` 6 for P=8, 10 for P=16 and 18 for P=32.
- Exactly one strobe per complete bit period, and FRAME_BITS strobes per complete frame of FRAME_BITS·P enabled cycles.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `DATA_SAMPLER_MAJORITY_EN` defined:
  - `sampled_bit` = majority(s0, s1, s2).
  - A single-edge glitch at any one of the three sample points is rejected.
- `DATA_SAMPLER_MAJORITY_EN` not defined:
  - `sampled_bit` = s1, a single centre sample.
  - s0 and s2 are not implemented.
  - Strobe timing is unchanged (`edge_cnt == mid+2`).

## Structure
- Shared package `uart_rx_pkg`, which holds:
  - legal prescale constants PRESC_8, PRESC_16 and PRESC_32;
  - the default `FRAME_BITS`;
  - the `bit_cnt` width.
- Sub-module `edge_bit_counter` holds the `edge_cnt`/`bit_cnt` logic, including the wrap and enable clearing. The top level holds the sample registers, the vote and the strobe.

## Test plan
- P=8, enable held, `RX_IN`=1 constant -> `sample_valid` high at `edge_cnt`=6 every 8 cycles; `sampled_bit`=1.
- P=16, `RX_IN`=0 except high for the single cycle at `edge_cnt`=8 -> `sampled_bit`=0 with the macro defined, 1 without it.
- P=8, `FRAME_BITS`=11, enable held for 88 cycles -> `bit_cnt` steps 0..10, returns to 0 at cycle 88; 11 strobes in total.
- Enable dropped at `edge_cnt`=3 -> next cycle `edge_cnt`=0 and `bit_cnt`=0; no strobe for that bit. Re-enable -> first strobe 7 cycles later (P=8).
- `RST` pulsed at `bit_cnt`=5 -> next cycle all outputs 0. Counting resumes from 0 if enable is still high.
- `prescale`=12 -> identical behaviour to P=8; `prescale`=32 -> strobe at `edge_cnt`=18.
